serial_send_sched: RTL and testbench
====================================

// Module: serial_send_sched
// PURPOSE
//  Frame scheduler in front of the 16-bit serial_send datapath, in the CLKF domain.
//  Shares the serial link between N_REQ word sources with round-robin arbitration.
//  Wraps each granted burst as a frame: header, payload, optional checksum.
//  Drives a continuous 16-bit word stream to serial_send DIN, one word per CLKF cycle.
//  Fills every unused cycle with the IDLE/sync word.
// PARAMETERS
//  N_REQ        4        number of requesters, 2..16
//  SYNC_PERIOD  256      max cycles between forced sync words, >=16
// PORTS
//  CLKF      in   1         fast word clock, same clock as serial_send CLKF
//  RSTF      in   1         synchronous reset, active-high
//  REQ       in   N_REQ     per-requester frame request, level
//  LEN       in   8*N_REQ   per-requester payload length in words; slice i is LEN[8i+7:8i]
//  DATA      in   16*N_REQ  per-requester current payload word, show-ahead
//  POP       out  N_REQ     one-hot; DATA slice i consumed this cycle
//  GNT       out  N_REQ     one-hot; requester owning the current frame
//  DOUT      out  16        word to serial_send DIN, registered
//  SOF       out  1         DOUT holds a header word
//  BUSY      out  1         frame in progress (state is not IDLE)
// BEHAVIOUR
//  Reset values
//   - After RSTF: DOUT=16'hBC50 (IDLE word); POP=0, GNT=0, SOF=0, BUSY=0.
//   - Round-robin pointer resets to 0; sync counter resets to 0.
//  States
//   - IDLE: emit 16'hBC50.
//   - SYNC: emit 16'hBC50 once.
//   - HDR: emit {4'hA, src[3:0], len[7:0]}.
//   - PAY: emit payload words.
//   - CKS: checksum word, only with SSEND_CKSUM_EN.
//  Transitions
//   - IDLE -> SYNC when any REQ is high and sync_cnt >= SYNC_PERIOD-16.
//   - IDLE -> HDR when any REQ is high otherwise.
//   - SYNC -> HDR.
//   - HDR -> PAY when len != 0.
//   - HDR -> IDLE when len == 0 (or -> CKS with checksum enabled).
//   - PAY -> IDLE after the len-th word (or -> CKS); CKS -> IDLE.
//  Arbitration
//   - Performed only in IDLE.
//   - Winner = first REQ at or above rr_ptr, wrapping modulo N_REQ.
//   - On grant: rr_ptr <= winner+1, wrapping N_REQ-1 -> 0.
//   - src and len are latched at grant.
//   - REQ and LEN changes after grant are ignored until the frame ends.
//  GNT and POP timing
//   - GNT is asserted from the HDR cycle through the last frame word.
//   - POP[i] is high in the cycle DATA slice i is registered into DOUT.
//   - Exactly len POPs per frame.
//   - Requester must present the next word in the cycle after each POP.
//  Latency
//   - REQ rising in IDLE -> header on DOUT 2 cycles later (grant cycle + register).
//   - Add 1 cycle when SYNC is inserted.
//   - Back-to-back frames are separated by at least 1 IDLE word.
//  Sync counter
//   - Increments every cycle, saturating at SYNC_PERIOD.
//   - Clears whenever DOUT=16'hBC50.
//   - In IDLE, the IDLE word itself satisfies the sync requirement.
//  Boundaries
//   - len=255: PAY runs exactly 255 cycles; internal counter is 8 bits with no wrap.
//   - All REQ low: stay in IDLE.
//   - Single requester holding REQ: frames repeat with 1 IDLE between them.
//   - RSTF asserted mid-frame: next cycle returns to reset values; the frame is truncated.
// CONFIGURATION
//  SSEND_CKSUM_EN defined
//   - One trailer word after the payload (also after a header-only frame).
//   - Trailer = 16-bit XOR of the header and all payload words.
//   - Header bit 15:12 becomes 4'hB to flag checksum frames.
//  SSEND_CKSUM_EN undefined
//   - No CKS state; header nibble is 4'hA.
// STRUCTURE
//  Package serial_send_pkg holds:
//   - IDLE_WORD = 16'hBC50
//   - HDR_TAG = 4'hA, HDR_TAG_CK = 4'hB
//   - state enum {IDLE, SYNC, HDR, PAY, CKS}
//  One sub-module: serial_send_rr_arb (N_REQ-wide round-robin pick).
//   - Inputs: req vector, pointer.
//   - Output: one-hot grant.
//   - Purely combinational; the pointer register lives in the parent.
//  FSM, length counter, sync counter, checksum and DOUT register sit in the parent.
// TESTING
//  1. Reset, no REQ for 50 cycles -> DOUT constant 16'hBC50; POP/GNT/SOF/BUSY all 0.
//  2. REQ[1]=1, LEN=3 -> DOUT sequence BC50, A103, D0, D1, D2, BC50.
//     POP[1] high for exactly 3 cycles; SOF high on A103 only.
//  3. REQ=4'b1011 held, LEN=1 each -> header sources 0,1,3,0,1,3...
//     Frames are separated by one BC50 word.
//  4. LEN=0 on req 2 -> A200 then BC50; no POP.
//     With SSEND_CKSUM_EN: B200, then 0xB200, then BC50.
//  5. SYNC_PERIOD=16; req 0 holds LEN=20 repeatedly -> SYNC word precedes every header.
//     Max gap between BC50 words <= SYNC_PERIOD+LEN+2.
//  6. RSTF pulsed at payload word 5 of a LEN=10 frame -> next DOUT=BC50, GNT=0.
//     Next grant goes to requester 0.

Source files
------------

// File: rtl/serial_send_pkg.sv
// Shared constants and state encoding for the serial_send frame scheduler.
// Optional checksum trailer is selected with SSEND_CKSUM_EN.
package serial_send_pkg;

  localparam logic [15:0] IDLE_WORD  = 16'hBC50;
  localparam logic [3:0]  HDR_TAG    = 4'hA;
  localparam logic [3:0]  HDR_TAG_CK = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR,
    PAY,
    CKS
  } state_t;

  function automatic logic [15:0] hdr_word(
    input logic [3:0] tag,
    input logic [3:0] src,
    input logic [7:0] len
  );
    return {tag, src, len};
  endfunction

endpackage

// File: rtl/serial_send_rr_arb.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
// The pointer register is owned by the parent.
module serial_send_rr_arb #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_send_sched.sv
// Round-robin frame scheduler driving the 16-bit serial_send word stream.
// Define SSEND_CKSUM_EN to append an XOR checksum trailer to every frame.
module serial_send_sched
  import serial_send_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SYNC_PERIOD = 256
) (
  input  logic                CLKF,
  input  logic                RSTF,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [8*N_REQ-1:0]  LEN,
  input  logic [16*N_REQ-1:0] DATA,
  output logic [N_REQ-1:0]    POP,
  output logic [N_REQ-1:0]    GNT,
  output logic [15:0]         DOUT,
  output logic                SOF,
  output logic                BUSY
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = $clog2(SYNC_PERIOD + 1);

  localparam logic [SW-1:0] SYNC_MAX = SW'(SYNC_PERIOD);
  localparam logic [SW-1:0] SYNC_THR = SW'(SYNC_PERIOD - 16);

`ifdef SSEND_CKSUM_EN
  localparam logic [3:0] TAG    = HDR_TAG_CK;
  localparam state_t     END_ST = CKS;
`else
  localparam logic [3:0] TAG    = HDR_TAG;
  localparam state_t     END_ST = IDLE;
`endif

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q;
  logic [PW-1:0]     src_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [PW-1:0]     rr_q, rr_next;
  logic [SW-1:0]     sync_q, sync_d;
  logic [15:0]       dout_q, dout_d;
  logic              sof_q, sof_d;
  logic              take;

  logic [N_REQ-1:0]  arb_gnt;
  logic [PW-1:0]     win_idx;
  logic [7:0]        len_sel;
  logic [15:0]       data_sel;
  logic [15:0]       hdr;

`ifdef SSEND_CKSUM_EN
  logic [15:0]       cks_q, cks_d;
`endif

  serial_send_rr_arb #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req (REQ),
    .ptr (rr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  assign len_sel  = LEN[win_idx*8 +: 8];
  assign data_sel = DATA[src_q*16 +: 16];
  assign hdr      = hdr_word(TAG, 4'(src_q), len_q);
  assign rr_next  = (win_idx == PW'(N_REQ-1))
                  ? '0 : win_idx + PW'(1);

  always_comb begin
    state_d = state_q;
    dout_d  = IDLE_WORD;
    sof_d   = 1'b0;
    take    = 1'b0;
    cnt_d   = cnt_q;
`ifdef SSEND_CKSUM_EN
    cks_d   = cks_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          take    = 1'b1;
          state_d = (sync_q >= SYNC_THR) ? SYNC : HDR;
        end
      end
      SYNC: state_d = HDR;
      HDR: begin
        dout_d  = hdr;
        sof_d   = 1'b1;
        cnt_d   = '0;
`ifdef SSEND_CKSUM_EN
        cks_d   = hdr;
`endif
        state_d = (len_q != 8'd0) ? PAY : END_ST;
      end
      PAY: begin
        dout_d = data_sel;
        cnt_d  = cnt_q + 8'd1;
`ifdef SSEND_CKSUM_EN
        cks_d  = cks_q ^ data_sel;
`endif
        if (cnt_q == len_q - 8'd1) state_d = END_ST;
      end
`ifdef SSEND_CKSUM_EN
      CKS: begin
        dout_d  = cks_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Any emitted sync word, including the idle filler, restarts the gap count
  always_comb begin
    sync_d = sync_q;
    if (dout_d == IDLE_WORD) sync_d = '0;
    else if (sync_q != SYNC_MAX) sync_d = sync_q + SW'(1);
  end

  always_ff @(posedge CLKF) begin
    if (RSTF) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
      sync_q  <= '0;
      dout_q  <= IDLE_WORD;
      sof_q   <= 1'b0;
`ifdef SSEND_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      dout_q  <= dout_d;
      sof_q   <= sof_d;
`ifdef SSEND_CKSUM_EN
      cks_q   <= cks_d;
`endif
      if (take) begin
        gnt_q <= arb_gnt;
        src_q <= win_idx;
        len_q <= len_sel;
        rr_q  <= rr_next;
      end
    end
  end

  assign POP  = (state_q == PAY) ? gnt_q : '0;
  assign GNT  = (state_q == HDR || state_q == PAY
              || state_q == CKS) ? gnt_q : '0;
  assign BUSY = (state_q != IDLE);
  assign DOUT = dout_q;
  assign SOF  = sof_q;

endmodule

// File: tb/tb_serial_send_sched.sv
// Randomized scoreboard bench for serial_send_sched against a frame-level model.
// Honours SSEND_CKSUM_EN the same way the design does.
module tb_serial_send_sched;
  import serial_send_pkg::*;

  localparam int N  = 4;
  localparam int SP = 64;

`ifdef SSEND_CKSUM_EN
  localparam logic [3:0] TAG = HDR_TAG_CK;
`else
  localparam logic [3:0] TAG = HDR_TAG;
`endif

  typedef struct {
    logic [15:0] w;
    logic        sof;
    logic        rst;
  } exp_t;

  logic            CLKF = 1'b0;
  logic            RSTF;
  logic [N-1:0]    REQ;
  logic [8*N-1:0]  LEN;
  logic [16*N-1:0] DATA;
  logic [N-1:0]    POP;
  logic [N-1:0]    GNT;
  logic [15:0]     DOUT;
  logic            SOF;
  logic            BUSY;

  always #5 CLKF = ~CLKF;

  serial_send_sched #(
    .N_REQ       (N),
    .SYNC_PERIOD (SP)
  ) dut (
    .CLKF (CLKF),
    .RSTF (RSTF),
    .REQ  (REQ),
    .LEN  (LEN),
    .DATA (DATA),
    .POP  (POP),
    .GNT  (GNT),
    .DOUT (DOUT),
    .SOF  (SOF),
    .BUSY (BUSY)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Payload word of requester i, word number c of its private stream
  function automatic logic [15:0] pay(input int i, input int c);
    return {4'(i), 12'(c)};
  endfunction

  // ---------------- reference model: frames as word lists ----------------
  int   rr_m;
  int   scnt;
  int   mcnt[N];
  exp_t pend[$];
  exp_t exp_q[$];

  task automatic build_frame();
    int w;
    int len;
    logic [15:0] h;
    logic [15:0] ck;
    logic [15:0] d;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (w < 0 && REQ[idx]) w = idx;
    end
    len = int'(LEN[w*8 +: 8]);
    h   = {TAG, 4'(w), 8'(len)};
    ck  = h;
    if (scnt >= SP - 16) pend.push_back('{IDLE_WORD, 1'b0, 1'b0});
    pend.push_back('{h, 1'b1, 1'b0});
    for (int k = 0; k < len; k++) begin
      d  = pay(w, mcnt[w] + k);
      ck = ck ^ d;
      pend.push_back('{d, 1'b0, 1'b0});
    end
`ifdef SSEND_CKSUM_EN
    pend.push_back('{ck, 1'b0, 1'b0});
`endif
    mcnt[w] += len;
    rr_m = (w + 1) % N;
  endtask

  initial begin
    exp_t e;
    rr_m = 0;
    scnt = 0;
    foreach (mcnt[i]) mcnt[i] = 0;
    forever begin
      @(posedge CLKF);
      if (RSTF) begin
        rr_m = 0;
        scnt = 0;
        pend.delete();
        foreach (mcnt[i]) mcnt[i] = 0;
        e = '{IDLE_WORD, 1'b0, 1'b1};
      end else begin
        if (pend.size() == 0) begin
          e = '{IDLE_WORD, 1'b0, 1'b0};
          if (REQ != '0) build_frame();
        end else begin
          e = pend.pop_front();
        end
        if (e.w == IDLE_WORD) scnt = 0;
        else if (scnt < SP) scnt = scnt + 1;
      end
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge CLKF);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL queue_empty: got DOUT %h expected nothing", DOUT);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(DOUT), 32'(e.w));
        chk("sof", 32'(SOF), 32'(e.sof));
        if (e.rst) begin
          chk("rst_gnt", 32'(GNT), 32'd0);
          chk("rst_pop", 32'(POP), 32'd0);
          chk("rst_busy", 32'(BUSY), 32'd0);
        end
      end
      chk("gnt_onehot", 32'($onehot0(GNT)), 32'd1);
      chk("pop_in_gnt", 32'(POP & ~GNT), 32'd0);
    end
  end

  // ---------------- requester data sources ----------------
  int         dcnt[N];
  logic [N-1:0] pop_prev;

  task automatic step(input bit do_rst);
    @(negedge CLKF);
    for (int i = 0; i < N; i++) if (pop_prev[i]) dcnt[i]++;
    RSTF = do_rst;
    if (do_rst) begin
      foreach (dcnt[i]) dcnt[i] = 0;
      pop_prev = '0;
    end else begin
      pop_prev = POP;
    end
    for (int i = 0; i < N; i++) DATA[i*16 +: 16] = pay(i, dcnt[i]);
  endtask

  initial begin
    RSTF     = 1'b1;
    REQ      = '0;
    LEN      = '0;
    pop_prev = '0;
    foreach (dcnt[i]) dcnt[i] = 0;
    for (int i = 0; i < N; i++) DATA[i*16 +: 16] = pay(i, 0);

    repeat (3) step(1'b1);
    repeat (50) step(1'b0);

    REQ = 4'b0010; LEN[15:8] = 8'd3;
    step(1'b0);
    REQ = '0;
    repeat (10) step(1'b0);

    REQ = 4'b1011; LEN = {8'd1, 8'd1, 8'd1, 8'd1};
    repeat (30) step(1'b0);
    REQ = '0;
    repeat (6) step(1'b0);

    REQ = 4'b0100; LEN[23:16] = 8'd0;
    step(1'b0);
    REQ = '0;
    repeat (6) step(1'b0);

    REQ = 4'b0100; LEN[23:16] = 8'd10;
    step(1'b0);
    REQ = '0;
    repeat (7) step(1'b0);
    step(1'b1);
    REQ = 4'b0101; LEN = {8'd2, 8'd2, 8'd2, 8'd2};
    step(1'b0);
    REQ = '0;
    repeat (12) step(1'b0);

    REQ = 4'b1000; LEN[31:24] = 8'd255;
    step(1'b0);
    REQ = '0;
    repeat (270) step(1'b0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) REQ = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 19))
            0:       LEN[i*8 +: 8] = 8'd0;
            1:       LEN[i*8 +: 8] = 8'd255;
            2, 3:    LEN[i*8 +: 8] = 8'($urandom_range(40, 70));
            default: LEN[i*8 +: 8] = 8'($urandom_range(1, 12));
          endcase
        end
      end
      step($urandom_range(0, 699) == 0);
    end

    REQ = '0;
    for (int k = 0; k < 600 && pend.size() != 0; k++) step(1'b0);
    repeat (4) step(1'b0);
    chk("drain", 32'(pend.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("pop_total", 32'(dcnt[i]), 32'(mcnt[i]));

    @(posedge CLKF);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
